// File: rtl/bus_grant_enc16.sv
`default_nettype none
// ============================================================================
// bus_grant_enc16 : round-robin 16-to-4 bus grant encoder with hold timer
//                   and a forced one-cycle turnaround between owners.
// Revision        : 1.0
// ============================================================================
module bus_grant_enc16 #(
   parameter int N_REQ    = 16,
   parameter int IDX_W    = 4,
   parameter int HOLD_MAX = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   localparam logic       HOLD_EN  = (HOLD_MAX != 0);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] cand;
   logic             pick_found;
   logic [7:0]       hold_cnt;
   logic [7:0]       hold_nxt;
   logic             gv_nxt;
   logic             to_nxt;
   logic             rel_done;
   logic             rel_drop;
   logic             rel_limit;
   logic             release_now;

   // First set request starting at ptr, wrapping naturally through the index width.
   always_comb begin
      pick       = ptr;
      pick_found = 1'b0;
      cand       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr + IDX_W'(k);
         if (!pick_found && req[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   assign rel_done    = done;
   assign rel_drop    = !req[grant_idx];
   assign rel_limit   = HOLD_EN && (hold_cnt == HOLD_LIM);
   assign release_now = rel_done || rel_drop || rel_limit;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = grant_idx;
      hold_nxt  = hold_cnt;
      gv_nxt    = grant_valid;
      to_nxt    = 1'b0;
      case (state)
         IDLE: begin
            gv_nxt = 1'b0;
            if (pick_found) begin
               idx_nxt   = pick;
               gv_nxt    = 1'b1;
               hold_nxt  = 8'd1;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               gv_nxt    = 1'b0;
               state_nxt = TURN;
               ptr_nxt   = grant_idx + IDX_W'(1);
               // Timeout flags only a purely timer-driven release.
               to_nxt    = rel_limit && !rel_done && !rel_drop;
            end else if (hold_cnt != 8'hFF) begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         TURN: begin
            gv_nxt    = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            gv_nxt    = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         grant_idx   <= '0;
         hold_cnt    <= 8'd0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         grant_idx   <= idx_nxt;
         hold_cnt    <= hold_nxt;
         grant_valid <= gv_nxt;
         timeout     <= to_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_grant_enc16.sv
`default_nettype none
// tb_bus_grant_enc16 : directed plus randomized stimulus against an owner/queue
// style reference model; per-cycle expectations are scoreboarded.
module tb_bus_grant_enc16;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic        timeout;

   bus_grant_enc16 #(.N_REQ(16), .IDX_W(4), .HOLD_MAX(HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit gv;
      int idx;
      bit to;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Reference model: who owns the bus, how long, and how many idle cycles remain.
   int  owner  = 0;   // last granted index (holds after release)
   bit  owned  = 0;
   int  gap    = 0;   // remaining non-arbitrating cycles after a release
   int  held   = 0;   // cycles of ownership so far, capped at 255
   int  next_p = 0;   // highest-priority requester for next arbitration
   bit  to_p   = 0;

   function automatic void model_edge(bit rn, logic [15:0] r, bit d);
      to_p = 0;
      if (!rn) begin
         owner = 0; owned = 0; gap = 0; held = 0; next_p = 0;
         return;
      end
      if (owned) begin
         bit at_limit = (HOLD > 0) && (held == HOLD);
         if (d || !r[owner] || at_limit) begin
            to_p   = at_limit && !d && r[owner];
            owned  = 0;
            next_p = (owner + 1) % 16;
            gap    = 1;
         end else if (held < 255) begin
            held++;
         end
      end else if (gap > 0) begin
         gap--;
      end else if (r != 16'h0) begin
         for (int k = 0; k < 16; k++) begin
            int c = (next_p + k) % 16;
            if (r[c]) begin
               owner = c;
               break;
            end
         end
         owned = 1;
         held  = 1;
      end
   endfunction

   task automatic cycle(input bit rn, input logic [15:0] r, input bit d);
      exp_t e;
      @(negedge clk);
      rst_n = rn;
      req   = r;
      done  = d;
      model_edge(rn, r, d);
      e.gv  = owned;
      e.idx = owner;
      e.to  = to_p;
      q.push_back(e);
   endtask

   // Monitor: every edge the DUT presents its registered outputs.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (grant_valid !== e.gv || int'(grant_idx) != e.idx || timeout !== e.to) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d got gv=%0b idx=%0d to=%0b want gv=%0b idx=%0d to=%0b",
                        cyc, grant_valid, grant_idx, timeout, e.gv, e.idx, e.to);
            end
         end
      end
   end

   initial begin
      logic [15:0] r;
      bit          d;
      // Reset with every requester active, then first grant must be index 0.
      repeat (3) cycle(0, 16'hFFFF, 0);
      for (int i = 0; i < 6; i++) cycle(1, 16'hFFFF, owned && held >= 2);

      // Single requester: grant idx 5, done after 3 cycles, re-grant.
      repeat (2) cycle(0, 16'h0000, 0);
      for (int i = 0; i < 12; i++) cycle(1, 16'h0020, owned && held == 3);

      // Round-robin with wrap: 0,1,15,0,1.
      repeat (1) cycle(0, 16'h0000, 0);
      for (int i = 0; i < 24; i++) cycle(1, 16'h8003, owned && held >= 2);

      // Timeout on persistent requester, then done on the limit edge.
      repeat (1) cycle(0, 16'h0000, 0);
      for (int i = 0; i < 14; i++) cycle(1, 16'h0100, 0);
      for (int i = 0; i < 14; i++) cycle(1, 16'h0100, owned && held == HOLD);

      // Owner withdraws: grant 3, drop it, next grant 10.
      repeat (1) cycle(0, 16'h0000, 0);
      cycle(1, 16'h0408, 0);
      cycle(1, 16'h0408, 0);
      for (int i = 0; i < 6; i++) cycle(1, 16'h0400, 0);

      // Reset mid-grant on idx 7, next grant goes to 0.
      repeat (1) cycle(0, 16'h0000, 0);
      for (int i = 0; i < 3; i++) cycle(1, 16'h0080, 0);
      cycle(0, 16'h0081, 0);
      for (int i = 0; i < 4; i++) cycle(1, 16'h0081, 0);

      // Randomized traffic.
      r = 16'($urandom);
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 7))
            0: r = 16'h0000;
            1: r = 16'h1 << $urandom_range(0, 15);
            2: r = 16'($urandom);
            3: r = 16'($urandom) & 16'($urandom);
            default: ;
         endcase
         d = ($urandom_range(0, 5) == 0);
         cycle(($urandom_range(0, 79) != 0), r, d);
      end

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
